// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared constants and helpers for the multi-digit BCD counter.
//               Holds the decade width, the legal digit limits and the
//               nibble clamp used when a parallel load is applied.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Bits per BCD decade
    localparam int unsigned BCD_W = 4;

    // Largest and smallest legal digit values
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    // Map any nibble onto a legal digit: 0..9 pass through, A..F become 9
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nib);
        if (nib > BCD_MAX) begin
            return BCD_MAX;
        end
        return nib;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_decade.sv
`default_nettype none
// ============================================================================
// Module      : bcd_decade
// Description : One BCD digit of the cascaded counter. Steps up or down on
//               step_in, loads a clamped nibble on load, and reports a
//               combinational carry/borrow to the next decade when it rolls
//               over in the current direction.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_decade
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             step_in,
    input  logic             up,
    input  logic             load,
    input  logic [BCD_W-1:0] load_nib,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    // Digit sits at the rollover point for the current direction
    logic at_limit;

    assign at_limit  = up ? (digit == BCD_MAX) : (digit == BCD_MIN);

    // Carry/borrow is combinational so the whole chain ripples in one cycle
    assign carry_out = step_in & at_limit;

    // Digit register: reset, then load, then step, otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= bcd_clamp(load_nib);
        end else if (step_in) begin
            if (up) begin
                digit <= at_limit ? BCD_MIN : (digit + 4'd1);
            end else begin
                digit <= at_limit ? BCD_MAX : (digit - 4'd1);
            end
        end
    end

endmodule : bcd_decade
`default_nettype wire

// File: rtl/bcd_multi_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_multi_counter
// Description : DIGITS cascaded BCD decades paced by a TICK_MAX-cycle
//               prescaler. Supports up/down counting, clamped parallel load,
//               and registered step / whole-counter wrap pulses. Digit 0 is
//               the least significant nibble of bcd / load_val.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_multi_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,            // 1..8 decades
    parameter int TICK_MAX = 100000000     // clock cycles per count step, >= 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] bcd,
    output logic                    step_o,
    output logic                    wrap_o
);

    // Prescaler needs at least one bit even when every cycle is a step
    localparam int unsigned       PRE_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_MAX - 1);

    logic [PRE_W-1:0] prescaler;
    logic             step;
    // chain[0] is the prescaler step; chain[k+1] is decade k's carry/borrow
    logic [DIGITS:0]  chain;

    assign step     = en & (prescaler == PRE_LAST);
    assign chain[0] = step;

    // Prescaler: cleared by reset or load, frozen while en is low
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
        end else if (load) begin
            prescaler <= '0;
        end else if (en) begin
            prescaler <= (prescaler == PRE_LAST) ? '0 : (prescaler + 1'b1);
        end
    end

    // One decade per digit, each stepped by the carry of the one below
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            bcd_decade u_decade (
                .clk       (clk),
                .reset     (reset),
                .step_in   (chain[k]),
                .up        (up),
                .load      (load),
                .load_nib  (load_val[k*BCD_W +: BCD_W]),
                .digit     (bcd[k*BCD_W +: BCD_W]),
                .carry_out (chain[k+1])
            );
        end
    endgenerate

    // Output pulses line up with the new count; a load suppresses both
    always_ff @(posedge clk) begin
        if (reset) begin
            step_o <= 1'b0;
            wrap_o <= 1'b0;
        end else begin
            step_o <= step & ~load;
            wrap_o <= chain[DIGITS] & ~load;
        end
    end

endmodule : bcd_multi_counter
`default_nettype wire

// File: tb/tb_bcd_multi_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_multi_counter
// Description : Directed self-checking bench. Instance a runs DIGITS=2,
//               TICK_MAX=4; instance b runs DIGITS=4, TICK_MAX=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_multi_counter;

    logic        clk;
    logic        reset;

    logic        en_a, up_a, load_a;
    logic [7:0]  load_val_a;
    logic [7:0]  bcd_a;
    logic        step_a, wrap_a;

    logic        en_b, up_b, load_b;
    logic [15:0] load_val_b;
    logic [15:0] bcd_b;
    logic        step_b, wrap_b;

    int checks;
    int fails;

    bcd_multi_counter #(.DIGITS(2), .TICK_MAX(4)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .en       (en_a),
        .up       (up_a),
        .load     (load_a),
        .load_val (load_val_a),
        .bcd      (bcd_a),
        .step_o   (step_a),
        .wrap_o   (wrap_a)
    );

    bcd_multi_counter #(.DIGITS(4), .TICK_MAX(1)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .en       (en_b),
        .up       (up_b),
        .load     (load_b),
        .load_val (load_val_b),
        .bcd      (bcd_b),
        .step_o   (step_b),
        .wrap_o   (wrap_b)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; leaves time 1 ns after the last rising edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] exp_bcd;
        checks     = 0;
        fails      = 0;
        reset      = 1'b1;
        en_a       = 1'b0; up_a = 1'b1; load_a = 1'b0; load_val_a = 8'h00;
        en_b       = 1'b0; up_b = 1'b1; load_b = 1'b0; load_val_b = 16'h0000;
        tick(2);
        reset = 1'b0;

        // Reset state
        check_eq("rst_bcd",  {24'd0, bcd_a}, 32'h00);
        check_eq("rst_step", {31'd0, step_a}, 32'd0);
        check_eq("rst_wrap", {31'd0, wrap_a}, 32'd0);

        // Count up 00..10, one step per 4 cycles
        en_a = 1'b1;
        up_a = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(3);
            check_eq("up_hold_step", {31'd0, step_a}, 32'd0);
            check_eq("up_hold_bcd",  {24'd0, bcd_a}, 32'((k - 1) / 10 * 16 + (k - 1) % 10));
            tick(1);
            exp_bcd = 8'((k / 10) * 16 + (k % 10));
            check_eq("up_bcd",  {24'd0, bcd_a}, {24'd0, exp_bcd});
            check_eq("up_step", {31'd0, step_a}, 32'd1);
        end

        // Load 98, count up to 99 then wrap to 00
        load_a = 1'b1; load_val_a = 8'h98;
        tick(1);
        load_a = 1'b0;
        check_eq("ld98_bcd",  {24'd0, bcd_a}, 32'h98);
        check_eq("ld98_step", {31'd0, step_a}, 32'd0);
        tick(4);
        check_eq("up99_bcd",  {24'd0, bcd_a}, 32'h99);
        check_eq("up99_wrap", {31'd0, wrap_a}, 32'd0);
        tick(4);
        check_eq("wrap00_bcd",  {24'd0, bcd_a}, 32'h00);
        check_eq("wrap00_wrap", {31'd0, wrap_a}, 32'd1);
        check_eq("wrap00_step", {31'd0, step_a}, 32'd1);
        tick(1);
        check_eq("wrap00_pulse_end", {31'd0, wrap_a}, 32'd0);

        // Down: 10 -> 09 borrows, 00 -> 99 wraps
        load_a = 1'b1; load_val_a = 8'h10; up_a = 1'b0;
        tick(1);
        load_a = 1'b0;
        tick(4);
        check_eq("dn09_bcd",  {24'd0, bcd_a}, 32'h09);
        check_eq("dn09_wrap", {31'd0, wrap_a}, 32'd0);
        load_a = 1'b1; load_val_a = 8'h00;
        tick(1);
        load_a = 1'b0;
        tick(4);
        check_eq("dn99_bcd",  {24'd0, bcd_a}, 32'h99);
        check_eq("dn99_wrap", {31'd0, wrap_a}, 32'd1);

        // Load FA exactly when an up-step from 99 would wrap: load wins, no pulses
        up_a = 1'b1;
        tick(3);
        load_a = 1'b1; load_val_a = 8'hFA;
        tick(1);
        load_a = 1'b0;
        check_eq("ldFA_bcd",  {24'd0, bcd_a}, 32'h99);
        check_eq("ldFA_step", {31'd0, step_a}, 32'd0);
        check_eq("ldFA_wrap", {31'd0, wrap_a}, 32'd0);

        // Enable gap: 2 cycles in, hold 10 cycles, step 2 enabled cycles later
        load_a = 1'b1; load_val_a = 8'h42;
        tick(1);
        load_a = 1'b0;
        tick(2);
        en_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check_eq("en_lo_bcd",  {24'd0, bcd_a}, 32'h42);
            check_eq("en_lo_step", {31'd0, step_a}, 32'd0);
        end
        en_a = 1'b1;
        tick(1);
        check_eq("en_hi_1_bcd", {24'd0, bcd_a}, 32'h42);
        tick(1);
        check_eq("en_hi_2_bcd",  {24'd0, bcd_a}, 32'h43);
        check_eq("en_hi_2_step", {31'd0, step_a}, 32'd1);

        // Reset in the cycle a step is due
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("rst_due_bcd",  {24'd0, bcd_a}, 32'h00);
        check_eq("rst_due_step", {31'd0, step_a}, 32'd0);
        check_eq("rst_due_wrap", {31'd0, wrap_a}, 32'd0);
        tick(1);
        check_eq("rst_after_step", {31'd0, step_a}, 32'd0);
        check_eq("rst_after_bcd",  {24'd0, bcd_a}, 32'h00);
        en_a = 1'b0;

        // TICK_MAX=1, DIGITS=4: step every enabled cycle
        en_b = 1'b1;
        up_b = 1'b1;
        tick(1);
        check_eq("t1_bcd_1",  {16'd0, bcd_b}, 32'h0001);
        check_eq("t1_step_1", {31'd0, step_b}, 32'd1);
        tick(1);
        check_eq("t1_bcd_2",  {16'd0, bcd_b}, 32'h0002);
        load_b = 1'b1; load_val_b = 16'h9999;
        tick(1);
        load_b = 1'b0;
        check_eq("t1_ld_bcd",  {16'd0, bcd_b}, 32'h9999);
        check_eq("t1_ld_step", {31'd0, step_b}, 32'd0);
        tick(1);
        check_eq("t1_wrap_bcd", {16'd0, bcd_b}, 32'h0000);
        check_eq("t1_wrap",     {31'd0, wrap_b}, 32'd1);
        tick(1);
        check_eq("t1_after_bcd",  {16'd0, bcd_b}, 32'h0001);
        check_eq("t1_after_wrap", {31'd0, wrap_b}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_bcd_multi_counter
`default_nettype wire
